mdu_iter: RTL and testbench

- Multi-cycle multiply/divide unit with HI/LO result registers for the 5-stage pipeline, sitting in the E stage beside the ALU.
- Generalises the single-cycle ALU path in three ways: width-parametrised operands, iterative radix-2 division, and configurable multiply latency.
- Exposes a busy/done handshake so the hazard unit can stall D-stage MDU instructions, mfhi and mflo while an operation is in flight.

---
 rtl/mdu_iter.sv | 169 ++++++++++++++++
 tb/tb_mdu_iter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// mdu_iter: multi-cycle multiply/divide unit with HI/LO result registers.
// Multiplies complete after MUL_CYCLES cycles. Divides use one restoring
// radix-2 step per cycle, followed by a single sign-fixup cycle.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no operation in flight; start is accepted here
// MUL      | multiply latency countdown; the product is committed at cnt==0
// DIV_ITER | one restoring quotient bit per cycle, WIDTH cycles in total
// DIV_FIX  | apply signs and the divide-by-zero result, then commit HI/LO
module mdu_iter #(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 5,
   parameter int CNT_W      = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {IDLE, MUL, DIV_ITER, DIV_FIX} state_t;

   state_t                  state, state_nxt;
   logic [CNT_W-1:0]        cnt;
   logic signed [WIDTH:0]   mul_a, mul_b;
   logic [2*WIDTH-1:0]      prod;
   logic [WIDTH-1:0]        div_b, rem, quo, a_orig;
   logic                    q_neg, r_neg;
   logic                    is_mul, is_div, sgn;
   logic [WIDTH-1:0]        a_abs, b_abs;
   logic [WIDTH:0]          rem_sh;
   logic                    ge;
   logic [WIDTH-1:0]        diff, quo_fix, rem_fix;

   assign is_mul = (op == 3'b000) || (op == 3'b001);
   assign is_div = (op == 3'b010) || (op == 3'b011);
   assign sgn    = ~op[0];
   assign busy   = (state != IDLE);

   // Signed operands are extended by one bit so a single signed multiply
   // handles both MULT and MULTU; only the low 2*WIDTH bits are kept.
   assign prod = (2*WIDTH)'(mul_a) * (2*WIDTH)'(mul_b);

   // Negating the most negative value yields 2^(WIDTH-1), which is the
   // correct magnitude when the result is read as unsigned.
   assign a_abs = (sgn && a[WIDTH-1]) ? -a : a;
   assign b_abs = (sgn && b[WIDTH-1]) ? -b : b;

   assign rem_sh  = {rem, quo[WIDTH-1]};
   assign ge      = rem_sh >= {1'b0, div_b};
   assign diff    = rem_sh[WIDTH-1:0] - div_b;
   assign quo_fix = q_neg ? -quo : quo;
   assign rem_fix = r_neg ? -rem : rem;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state decode; abort returns any in-flight operation to IDLE
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start && is_mul)      state_nxt = MUL;
            else if (start && is_div) state_nxt = DIV_ITER;
         end
         MUL: begin
            if (abort || (cnt == '0)) state_nxt = IDLE;
         end
         DIV_ITER: begin
            if (abort)                state_nxt = IDLE;
            else if (cnt == '0)       state_nxt = DIV_FIX;
         end
         DIV_FIX:                     state_nxt = IDLE;
         default:                     state_nxt = IDLE;
      endcase
   end

   // Datapath: operand capture, iteration and HI/LO commit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt    <= '0;
         mul_a  <= '0;
         mul_b  <= '0;
         div_b  <= '0;
         rem    <= '0;
         quo    <= '0;
         a_orig <= '0;
         q_neg  <= 1'b0;
         r_neg  <= 1'b0;
         done   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  case (op)
                     3'b000, 3'b001: begin
                        mul_a <= {sgn & a[WIDTH-1], a};
                        mul_b <= {sgn & b[WIDTH-1], b};
                        cnt   <= CNT_W'(MUL_CYCLES - 1);
                     end
                     3'b010, 3'b011: begin
                        rem    <= '0;
                        quo    <= a_abs;
                        div_b  <= b_abs;
                        a_orig <= a;
                        q_neg  <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_neg  <= sgn & a[WIDTH-1];
                        cnt    <= CNT_W'(WIDTH - 1);
                     end
                     3'b100:  hi <= a;
                     3'b101:  lo <= a;
                     default: ;
                  endcase
               end
            end
            MUL: begin
               if (!abort) begin
                  if (cnt == '0) begin
                     {hi, lo} <= prod;
                     done     <= 1'b1;
                  end else begin
                     cnt <= cnt - CNT_W'(1);
                  end
               end
            end
            DIV_ITER: begin
               if (!abort) begin
                  if (ge) begin
                     rem <= diff;
                     quo <= {quo[WIDTH-2:0], 1'b1};
                  end else begin
                     rem <= rem_sh[WIDTH-1:0];
                     quo <= {quo[WIDTH-2:0], 1'b0};
                  end
                  if (cnt != '0) cnt <= cnt - CNT_W'(1);
               end
            end
            DIV_FIX: begin
               if (!abort) begin
                  if (div_b == '0) begin
                     hi <= a_orig;
                     lo <= '1;
                  end else begin
                     hi <= rem_fix;
                     lo <= quo_fix;
                  end
                  done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: an arithmetic reference model runs alongside the DUT
// and is compared on every falling edge. Directed literal checks pin the model.
module tb_mdu_iter;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic [2:0]   op = 3'b111;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         abort = 1'b0;
   logic         busy, done;
   logic [W-1:0] hi, lo;

   int checks = 0;
   int errors = 0;
   bit run_cmp = 1'b0;

   mdu_iter #(.WIDTH(W), .MUL_CYCLES(5), .CNT_W(6)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .abort(abort), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference result from plain integer arithmetic
   function automatic void calc(input logic [2:0] o, input logic [W-1:0] x, y,
                                output logic [W-1:0] rh, output logic [W-1:0] rl);
      longint sx, sy, q, r;
      logic [63:0] p;
      rh = '0;
      rl = '0;
      case (o)
         3'd0: begin
            p  = 64'(longint'($signed(x)) * longint'($signed(y)));
            rh = p[63:32];
            rl = p[31:0];
         end
         3'd1: begin
            p  = 64'(longint'(x) * longint'(y));
            rh = p[63:32];
            rl = p[31:0];
         end
         3'd2, 3'd3: begin
            if (y == '0) begin
               rh = x;
               rl = '1;
            end else begin
               sx = (o == 3'd2) ? longint'($signed(x)) : longint'(x);
               sy = (o == 3'd2) ? longint'($signed(y)) : longint'(y);
               q  = sx / sy;
               r  = sx % sy;
               rl = q[31:0];
               rh = r[31:0];
            end
         end
         default: ;
      endcase
   endfunction

   // Reference model: remaining busy cycles plus pending result
   int unsigned  left = 0;
   logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
   bit           m_done = 1'b0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         left = 0; m_hi = '0; m_lo = '0; m_done = 1'b0;
      end else begin
         m_done = 1'b0;
         if (left > 0) begin
            if (abort) left = 0;
            else begin
               left--;
               if (left == 0) begin
                  m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
               end
            end
         end else if (start) begin
            case (op)
               3'd0, 3'd1: begin calc(op, a, b, p_hi, p_lo); left = 5; end
               3'd2, 3'd3: begin calc(op, a, b, p_hi, p_lo); left = W + 1; end
               3'd4: m_hi = a;
               3'd5: m_lo = a;
               default: ;
            endcase
         end
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (run_cmp && !reset) begin
         chk("busy", W'(busy), W'(left != 0));
         chk("done", W'(done), W'(m_done));
         chk("hi", hi, m_hi);
         chk("lo", lo, m_lo);
      end
   end

   task automatic issue(input logic [2:0] o, input logic [W-1:0] x, y);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clk);
      start = 1'b0; op = 3'b111;
   endtask

   // Counts busy cycles and checks done coincides with busy falling
   task automatic wait_idle(input string nm, input int exp_cycles);
      int n = 0;
      while (busy === 1'b1 && n < 200) begin
         n++;
         @(negedge clk);
      end
      chk({nm, "_cycles"}, W'(n), W'(exp_cycles));
      chk({nm, "_done"}, W'(done), W'(1));
   endtask

   initial begin
      reset = 1'b1;
      #22;
      chk("rst_busy", W'(busy), W'(0));
      chk("rst_hi", hi, '0);
      chk("rst_lo", lo, '0);
      @(negedge clk);
      reset = 1'b0;
      run_cmp = 1'b1;
      chk("rst_done", W'(done), W'(0));

      issue(3'd1, 32'hFFFF_FFFF, 32'd2);
      wait_idle("multu", 5);
      chk("multu_hi", hi, 32'h0000_0001);
      chk("multu_lo", lo, 32'hFFFF_FFFE);

      issue(3'd0, -32'sd3, 32'sd7);
      wait_idle("mult", 5);
      chk("mult_hi", hi, 32'hFFFF_FFFF);
      chk("mult_lo", lo, 32'hFFFF_FFEB);

      issue(3'd2, -32'sd7, 32'sd2);
      wait_idle("div", 33);
      chk("div_lo", lo, 32'hFFFF_FFFD);
      chk("div_hi", hi, 32'hFFFF_FFFF);

      issue(3'd3, 32'd100, 32'd7);
      wait_idle("divu", 33);
      chk("divu_lo", lo, 32'd14);
      chk("divu_hi", hi, 32'd2);

      issue(3'd3, 32'h1234, 32'd0);
      wait_idle("divz", 33);
      chk("divz_lo", lo, 32'hFFFF_FFFF);
      chk("divz_hi", hi, 32'h0000_1234);

      issue(3'd2, -32'sd5, 32'd0);
      wait_idle("sdivz", 33);
      chk("sdivz_lo", lo, 32'hFFFF_FFFF);
      chk("sdivz_hi", hi, 32'hFFFF_FFFB);

      issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle("ovf", 33);
      chk("ovf_lo", lo, 32'h8000_0000);
      chk("ovf_hi", hi, 32'h0);

      // start held high through busy with changing operands is ignored
      @(negedge clk);
      start = 1'b1; op = 3'd1; a = 32'd10; b = 32'd20;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (busy !== 1'b1) break;
         a = $urandom; b = $urandom;
      end
      start = 1'b0; op = 3'b111;
      chk("hold_busy", W'(busy), W'(0));
      chk("hold_hi", hi, 32'd0);
      chk("hold_lo", lo, 32'd200);

      // abort with start while idle: the new op is accepted
      @(negedge clk);
      start = 1'b1; abort = 1'b1; op = 3'd0; a = -32'sd3; b = 32'sd7;
      @(negedge clk);
      start = 1'b0; abort = 1'b0; op = 3'b111;
      chk("abst_busy", W'(busy), W'(1));
      wait_idle("abst", 5);
      chk("abst_lo", lo, 32'hFFFF_FFEB);

      issue(3'd4, 32'hAAAA, 32'd0);
      chk("mthi_hi", hi, 32'hAAAA);
      chk("mthi_busy", W'(busy), W'(0));
      issue(3'd5, 32'h5555, 32'd0);
      chk("mtlo_lo", lo, 32'h5555);

      // abort part-way through a divide
      issue(3'd3, 32'd1000, 32'd3);
      repeat (9) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", W'(busy), W'(0));
      chk("abort_done", W'(done), W'(0));
      repeat (3) @(negedge clk);
      chk("abort_hi", hi, 32'hAAAA);
      chk("abort_lo", lo, 32'h5555);

      // asynchronous reset mid-iteration
      issue(3'd3, 32'd100, 32'd7);
      repeat (5) @(negedge clk);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("arst_busy", W'(busy), W'(0));
      chk("arst_hi", hi, '0);
      chk("arst_lo", lo, '0);
      @(negedge clk);
      reset = 1'b0;

      issue(3'd1, 32'd3, 32'd4);
      wait_idle("post", 5);
      chk("post_lo", lo, 32'd12);
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
